reg_file_mp: RTL and testbench

- Parametrised multi-port register file, next generation of the team's 32x8 register file.
- Provides NUM_RD registered read ports and one write port, each with its own valid handshake.
- Adds three features:
  - optional write-first bypass;
  - optional hardwired-zero register 0;
  - a sequenced bulk-clear engine with a busy/ready indication.
- Sits between decode/issue logic and the datapath as the architectural register store.

---
 rtl/reg_file_mp.sv | 90 +++++++++
 tb/tb_reg_file_mp.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/reg_file_mp.sv
// Multi-port architectural register file: NUM_RD registered read ports, one write port,
// optional write-first bypass, optional hardwired-zero r0 and a sequenced bulk clear.
module reg_file_mp #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned ADDR_W      = 5,
    parameter int unsigned NUM_RD      = 2,
    parameter bit          WRITE_FIRST = 1'b1,
    parameter bit          ZERO_REG    = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     clr_req,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_valid,
    output logic                     wr_ack,
    output logic                     ready,
    output logic                     busy
);
    localparam int unsigned   DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] CLR_LAST = (ADDR_W + 1)'(DEPTH - 1);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W:0]   clr_cnt;
    logic [DATA_W-1:0] rd_next [NUM_RD];
    logic              wr_drop;

    assign ready   = (state == IDLE);
    assign busy    = (state == CLEAR);
    assign wr_drop = ZERO_REG && (wr_addr == '0);

    // Bypass first, then zero mask, so a bypassed write to r0 still reads as 0.
    always_comb begin
        for (int unsigned p = 0; p < NUM_RD; p++) begin
            rd_next[p] = mem[rd_addr[p*ADDR_W +: ADDR_W]];
            if (WRITE_FIRST && wr_en && (wr_addr == rd_addr[p*ADDR_W +: ADDR_W]))
                rd_next[p] = wr_data;
            if (ZERO_REG && (rd_addr[p*ADDR_W +: ADDR_W] == '0))
                rd_next[p] = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++)
                mem[i] <= '0;
            rd_data  <= '0;
            rd_valid <= '0;
            wr_ack   <= 1'b0;
            state    <= IDLE;
            clr_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    for (int unsigned p = 0; p < NUM_RD; p++) begin
                        rd_valid[p] <= rd_en[p];
                        if (rd_en[p])
                            rd_data[p*DATA_W +: DATA_W] <= rd_next[p];
                    end
                    wr_ack <= wr_en;
                    if (wr_en && !wr_drop)
                        mem[wr_addr] <= wr_data;
                    if (clr_req) begin
                        state   <= CLEAR;
                        clr_cnt <= '0;
                    end
                end
                CLEAR: begin
                    rd_valid                   <= '0;
                    wr_ack                     <= 1'b0;
                    mem[clr_cnt[ADDR_W-1:0]]   <= '0;
                    clr_cnt                    <= clr_cnt + 1'b1;
                    if (clr_cnt == CLR_LAST)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: dut_a uses the default build, dut_b uses WRITE_FIRST=0
// and ZERO_REG=1; both share stimulus and are checked against their own expectations.
module tb_reg_file_mp;
    localparam int DW = 8;
    localparam int AW = 5;
    localparam int NR = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [NR-1:0]    rd_en = '0;
    logic [NR*AW-1:0] rd_addr = '0;
    logic             wr_en = 1'b0;
    logic [AW-1:0]    wr_addr = '0;
    logic [DW-1:0]    wr_data = '0;
    logic             clr_req = 1'b0;

    logic [NR*DW-1:0] data_a, data_b;
    logic [NR-1:0]    valid_a, valid_b;
    logic             ack_a, ack_b, ready_a, ready_b, busy_a, busy_b;

    always #5 clk = ~clk;

    reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .WRITE_FIRST(1'b1), .ZERO_REG(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr(rd_addr), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .clr_req(clr_req), .rd_data(data_a),
        .rd_valid(valid_a), .wr_ack(ack_a), .ready(ready_a), .busy(busy_a));

    reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .WRITE_FIRST(1'b0), .ZERO_REG(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr(rd_addr), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .clr_req(clr_req), .rd_data(data_b),
        .rd_valid(valid_b), .wr_ack(ack_b), .ready(ready_b), .busy(busy_b));

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
    task automatic drive(input logic [1:0] re, input logic [4:0] a1, input logic [4:0] a0,
                         input logic we, input logic [4:0] wa, input logic [7:0] wd,
                         input logic cr);
        @(negedge clk);
        rd_en   = re;
        rd_addr = {a1, a0};
        wr_en   = we;
        wr_addr = wa;
        wr_data = wd;
        clr_req = cr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 8'h00, 1'b0);
    endtask

    typedef struct {
        logic [1:0]  re;
        logic [4:0]  a1;
        logic [4:0]  a0;
        logic        we;
        logic [4:0]  wa;
        logic [7:0]  wd;
        logic [15:0] ea;
        logic [15:0] eb;
        logic [1:0]  ev;
        logic        ek;
    } vec_t;

    vec_t vt[13];

    initial begin
        logic [15:0] m;
        int bc;

        vt[0]  = '{2'b11, 5'd31, 5'd7,  1'b0, 5'd0,  8'h00, 16'h0000, 16'h0000, 2'b11, 1'b0};
        vt[1]  = '{2'b00, 5'd0,  5'd0,  1'b0, 5'd0,  8'h00, 16'h0000, 16'h0000, 2'b00, 1'b0};
        vt[2]  = '{2'b00, 5'd0,  5'd0,  1'b1, 5'd5,  8'hA5, 16'h0000, 16'h0000, 2'b00, 1'b1};
        vt[3]  = '{2'b01, 5'd0,  5'd5,  1'b0, 5'd0,  8'h00, 16'h00A5, 16'h00A5, 2'b01, 1'b0};
        vt[4]  = '{2'b00, 5'd0,  5'd0,  1'b1, 5'd9,  8'h11, 16'h0000, 16'h0000, 2'b00, 1'b1};
        vt[5]  = '{2'b10, 5'd9,  5'd0,  1'b1, 5'd9,  8'h3C, 16'h3C00, 16'h1100, 2'b10, 1'b1};
        vt[6]  = '{2'b11, 5'd9,  5'd9,  1'b0, 5'd0,  8'h00, 16'h3C3C, 16'h3C3C, 2'b11, 1'b0};
        vt[7]  = '{2'b00, 5'd0,  5'd0,  1'b1, 5'd0,  8'hFF, 16'h0000, 16'h0000, 2'b00, 1'b1};
        vt[8]  = '{2'b11, 5'd0,  5'd0,  1'b0, 5'd0,  8'h00, 16'hFFFF, 16'h0000, 2'b11, 1'b0};
        vt[9]  = '{2'b11, 5'd5,  5'd0,  1'b1, 5'd0,  8'h77, 16'hA577, 16'hA500, 2'b11, 1'b1};
        vt[10] = '{2'b11, 5'd31, 5'd0,  1'b0, 5'd0,  8'h00, 16'h0077, 16'h0000, 2'b11, 1'b0};
        vt[11] = '{2'b11, 5'd31, 5'd31, 1'b1, 5'd31, 8'hEE, 16'hEEEE, 16'h0000, 2'b11, 1'b1};
        vt[12] = '{2'b11, 5'd31, 5'd31, 1'b0, 5'd0,  8'h00, 16'hEEEE, 16'hEEEE, 2'b11, 1'b0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst data_a", 32'(data_a), 32'h0);
        chk("rst valid_a", 32'(valid_a), 32'h0);
        chk("rst ack_a", 32'(ack_a), 32'h0);
        chk("rst ready_a", 32'(ready_a), 32'h1);
        chk("rst busy_a", 32'(busy_a), 32'h0);
        chk("rst busy_b", 32'(busy_b), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven vectors
        for (int i = 0; i < 13; i++) begin
            drive(vt[i].re, vt[i].a1, vt[i].a0, vt[i].we, vt[i].wa, vt[i].wd, 1'b0);
            m = {{8{vt[i].re[1]}}, {8{vt[i].re[0]}}};
            chk($sformatf("v%0d valid_a", i), 32'(valid_a), 32'(vt[i].ev));
            chk($sformatf("v%0d valid_b", i), 32'(valid_b), 32'(vt[i].ev));
            chk($sformatf("v%0d ack_a", i), 32'(ack_a), 32'(vt[i].ek));
            chk($sformatf("v%0d ack_b", i), 32'(ack_b), 32'(vt[i].ek));
            if (vt[i].re != 2'b00) begin
                chk($sformatf("v%0d data_a", i), 32'(data_a & m), 32'(vt[i].ea & m));
                chk($sformatf("v%0d data_b", i), 32'(data_b & m), 32'(vt[i].eb & m));
            end
        end
        idle();
        chk("pulse valid_a", 32'(valid_a), 32'h0);
        chk("pulse ack_a", 32'(ack_a), 32'h0);

        // Bulk clear: fill with addr+1, then clear while hammering reads/writes
        for (int a = 0; a < 32; a++) begin
            drive(2'b00, 5'd0, 5'd0, 1'b1, a[4:0], 8'(a + 1), 1'b0);
            chk("fill ack_a", 32'(ack_a), 32'h1);
        end
        drive(2'b11, 5'd15, 5'd0, 1'b0, 5'd0, 8'h00, 1'b0);
        chk("fill rd_a", 32'(data_a), 32'h1001);
        chk("fill rd_b", 32'(data_b), 32'h1000);

        drive(2'b01, 5'd0, 5'd20, 1'b1, 5'd3, 8'h99, 1'b1);
        chk("clr0 valid_a", 32'(valid_a), 32'h1);
        chk("clr0 data_a", 32'(data_a[7:0]), 32'h15);
        chk("clr0 ack_a", 32'(ack_a), 32'h1);
        chk("clr0 busy_a", 32'(busy_a), 32'h1);
        chk("clr0 ready_a", 32'(ready_a), 32'h0);
        chk("clr0 busy_b", 32'(busy_b), 32'h1);
        bc = 1;
        for (int i = 0; i < 40 && busy_a; i++) begin
            drive(2'b11, 5'd3, 5'd3, 1'b1, 5'd3, 8'h99, 1'b1);
            if (busy_a) bc++;
            chk("clr valid_a", 32'(valid_a), 32'h0);
            chk("clr ack_a", 32'(ack_a), 32'h0);
            chk("clr valid_b", 32'(valid_b), 32'h0);
            chk("clr hold_a", 32'(data_a[7:0]), 32'h15);
        end
        chk("clr busy cycles", 32'(bc), 32'd32);
        chk("clr done ready_a", 32'(ready_a), 32'h1);
        chk("clr done busy_b", 32'(busy_b), 32'h0);
        drive(2'b11, 5'd15, 5'd0, 1'b0, 5'd0, 8'h00, 1'b0);
        chk("post clr rd 15/0 a", 32'(data_a), 32'h0);
        chk("post clr rd 15/0 b", 32'(data_b), 32'h0);
        drive(2'b11, 5'd31, 5'd3, 1'b0, 5'd0, 8'h00, 1'b0);
        chk("post clr rd 31/3 a", 32'(data_a), 32'h0);
        chk("post clr valid_a", 32'(valid_a), 32'h3);

        // Reset in the middle of a clear
        drive(2'b00, 5'd0, 5'd0, 1'b1, 5'd25, 8'h25, 1'b0);
        drive(2'b00, 5'd0, 5'd0, 1'b1, 5'd4, 8'h44, 1'b0);
        drive(2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 8'h00, 1'b1);
        repeat (10) idle();
        chk("mid clr busy_a", 32'(busy_a), 32'h1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid rst busy_a", 32'(busy_a), 32'h0);
        chk("mid rst ready_a", 32'(ready_a), 32'h1);
        chk("mid rst busy_b", 32'(busy_b), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        drive(2'b11, 5'd4, 5'd25, 1'b0, 5'd0, 8'h00, 1'b0);
        chk("after rst rd 4/25 a", 32'(data_a), 32'h0);
        chk("after rst rd 4/25 b", 32'(data_b), 32'h0);
        drive(2'b00, 5'd0, 5'd0, 1'b1, 5'd3, 8'h5A, 1'b0);
        chk("after rst ack_a", 32'(ack_a), 32'h1);
        chk("after rst ack_b", 32'(ack_b), 32'h1);
        drive(2'b11, 5'd3, 5'd3, 1'b0, 5'd0, 8'h00, 1'b0);
        chk("after rst rd 3 a", 32'(data_a), 32'h5A5A);
        chk("after rst rd 3 b", 32'(data_b), 32'h5A5A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
